// File: rtl/seq_scan_ctrl_pkg.sv
// Shared definitions for the sequence scan controller and its pattern detector.
package seq_scan_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SHIFT  = 2'd1,
      REPORT = 2'd2
   } stateT;

   localparam int PATTERN_W = 4;
   localparam int HIST_W    = PATTERN_W - 1;
   localparam int FILL_W    = $clog2(HIST_W + 1);

   localparam logic [PATTERN_W-1:0] RESET_PATTERN = 4'b1011;

endpackage

// File: rtl/seq_detector_cfg.sv
// Overlapping 4-bit sequence detector with loadable pattern and persistent bit history.
// Z is Mealy: it reflects the bit presented this cycle against the stored history.
module seq_detector_cfg
   import seq_scan_ctrl_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 cfgLoad,
   input  logic [PATTERN_W-1:0] cfgPattern,
   input  logic                 bitValid,
   input  logic                 bitIn,
   output logic                 z
);

   logic [PATTERN_W-1:0] pattern;
   logic [HIST_W-1:0]    history;    // newest bit at [0], oldest at [HIST_W-1]
   logic [FILL_W-1:0]    fillCnt;
   logic                 histFull;

   assign histFull = (fillCnt == FILL_W'(HIST_W));
   assign z        = bitValid && histFull && ({history, bitIn} == pattern);

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values of its neighbours.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pattern <= RESET_PATTERN;
         history <= '0;
         fillCnt <= '0;
      end else if (cfgLoad) begin
         pattern <= cfgPattern;
         history <= '0;
         fillCnt <= '0;
      end else if (bitValid) begin
         history <= {history[HIST_W-2:0], bitIn};
         if (!histFull) begin
            fillCnt <= fillCnt + FILL_W'(1);
         end
      end
   end

endmodule

// File: rtl/seq_scan_ctrl.sv
// Word-serial scan controller: accepts a word, shifts it MSB-first through the
// pattern detector, then holds the saturating match count until consumed.
module seq_scan_ctrl
   import seq_scan_ctrl_pkg::*;
#(
   parameter int WORD_W = 8,
   parameter int CNT_W  = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 cfg_we,
   input  logic [PATTERN_W-1:0] cfg_pattern,
   input  logic                 in_valid,
   input  logic [WORD_W-1:0]    in_word,
   output logic                 in_ready,
   output logic                 out_valid,
   output logic [CNT_W-1:0]     out_count,
   input  logic                 out_ready,
   output logic                 busy,
   output logic                 Z
);

   localparam int                IDX_W    = $clog2(WORD_W);
   localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(WORD_W - 1);
   localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

   stateT             state;
   stateT             stateNext;
   logic [WORD_W-1:0] wordReg;
   logic [IDX_W-1:0]  bitIdx;
   logic [CNT_W-1:0]  matchCnt;
   logic              shiftEn;
   logic              accept;
   logic              cfgLoad;
   logic              detZ;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= stateNext;
      end
   end

   // NOTE: every output of this block gets a default first, so no path can
   // leave a signal unassigned and infer a latch.
   always_comb begin
      stateNext = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b0;
      shiftEn   = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               stateNext = SHIFT;
            end
         end
         SHIFT: begin
            busy    = 1'b1;
            shiftEn = 1'b1;
            if (bitIdx == LAST_IDX) begin
               stateNext = REPORT;
            end
         end
         REPORT: begin
            busy      = 1'b1;
            out_valid = 1'b1;
            if (out_ready) begin
               stateNext = IDLE;
            end
         end
         default: stateNext = IDLE;
      endcase
   end

   // Pattern writes are only honoured while idle; a write alongside an accepted
   // word therefore takes effect before the word's first bit.
   assign accept  = in_ready && in_valid;
   assign cfgLoad = in_ready && cfg_we;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wordReg  <= '0;
         bitIdx   <= '0;
         matchCnt <= '0;
      end else if (accept) begin
         wordReg  <= in_word;
         bitIdx   <= '0;
         matchCnt <= '0;
      end else if (shiftEn) begin
         wordReg <= {wordReg[WORD_W-2:0], 1'b0};
         bitIdx  <= bitIdx + IDX_W'(1);
         if (detZ && (matchCnt != CNT_MAX)) begin
            matchCnt <= matchCnt + CNT_W'(1);
         end
      end
   end

   seq_detector_cfg uDetector (
      .clk        (clk),
      .rst        (rst),
      .cfgLoad    (cfgLoad),
      .cfgPattern (cfg_pattern),
      .bitValid   (shiftEn),
      .bitIn      (wordReg[WORD_W-1]),
      .z          (detZ)
   );

   assign out_count = matchCnt;
   assign Z         = detZ;

endmodule

// File: doc/seq_scan_ctrl.md
SEQ_SCAN_CTRL -- requirements
Module: seq_scan_ctrl

Interface
REQ-001 SHALL have parameter WORD_W, default 8, meaning input word width in bits (>=4).
REQ-002 SHALL have parameter CNT_W, default 8, meaning match-count width in bits.
REQ-003 SHALL have port clk  in  1  sole clock; all state on rising edge.
REQ-004 SHALL have port rst  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port cfg_we  in  1  pattern write strobe.
REQ-006 SHALL have port cfg_pattern  in  4  new pattern, oldest bit at [3].
REQ-007 SHALL have port in_valid  in  1  input word offered.
REQ-008 SHALL have port in_word  in  WORD_W  word to scan, MSB shifted first.
REQ-009 SHALL have port in_ready  out  1  controller can accept a word.
REQ-010 SHALL have port out_valid  out  1  count result available.
REQ-011 SHALL have port out_count  out  CNT_W  matches found in last word.
REQ-012 SHALL have port out_ready  in  1  consumer accepts result.
REQ-013 SHALL have port busy  out  1  high in SHIFT or REPORT.
REQ-014 SHALL have port Z  out  1  per-bit match pulse (Mealy).

Function
REQ-015 SHALL implement FSM states IDLE, SHIFT, REPORT.
REQ-016 In IDLE: in_ready=1; on in_valid&in_ready edge latch in_word, clear bit index and word count, go SHIFT.
REQ-017 In SHIFT: present one bit per cycle, MSB first, to the detector; after WORD_W bits go REPORT; in_ready=0.
REQ-018 Z SHALL be 1 in the cycle the current bit plus the previous 3 history bits equal the pattern, only when >=3 history bits are valid; overlapping matches count.
REQ-019 Count SHALL increment on the same edge Z is high; saturate at 2^CNT_W-1.
REQ-020 In REPORT: out_valid=1, out_count held stable until out_valid&out_ready edge, then IDLE.
REQ-021 Latency: handshake edge at cycle t -> bits in t+1..t+WORD_W -> out_valid at t+WORD_W+1; min WORD_W+2 cycles/word.
REQ-022 Bit history SHALL persist across words (matches may span word boundary).
REQ-023 cfg_we SHALL be honoured only in IDLE: load pattern, clear history and its fill count; ignored in SHIFT/REPORT.
REQ-024 cfg_we and in_valid in the same IDLE cycle: both accepted; new pattern applies to that word.
REQ-025 Z SHALL be 0 outside SHIFT.

Reset
REQ-026 rst low SHALL immediately force IDLE, pattern=4'b1011, history and fill count cleared, count=0.
REQ-027 Outputs during/after reset: in_ready=1, out_valid=0, out_count=0, busy=0, Z=0.
REQ-028 Reset mid-SHIFT or mid-REPORT SHALL abandon the word; no result is emitted.

Structure
REQ-029 Shared package SHALL hold state encoding (IDLE/SHIFT/REPORT) and reset pattern constant 4'b1011.
REQ-030 Detector SHALL be a sub-module seq_detector_cfg (pattern, history shift register, fill count, Z); controller instantiates it once.

Verification
REQ-031 Reset pattern, word 8'b1011_0110 -> Z pulses at bits 3 and 6, out_count=2.
REQ-032 Word 8'h01 then 8'h60 -> counts 0 then 1 (match spans boundary, at bit 2 of second word).
REQ-033 WORD_W=16, CNT_W=3, pattern 4'b0000, word 16'h0000 after reset -> 13 matches, out_count saturates at 7.
REQ-034 out_ready held 0 for 5 cycles in REPORT -> out_valid/out_count stable, in_ready=0, new in_valid not accepted.
REQ-035 rst asserted at 3rd SHIFT bit -> all outputs at reset values same cycle; next word after release yields count from clean history.
REQ-036 cfg_we with 4'b0110 during SHIFT -> ignored, pattern stays 1011; in IDLE -> applied, next word 8'b0110_0110 gives 2.
